// File: rtl/game_pkg.sv
// game_pkg: shared FSM encoding, default coordinate width and clamped range test
package game_pkg;
  localparam int DEF_COORD_W = 10;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
  // Lower bound below zero behaves as zero.
  function automatic logic in_range(input int v, input int lo, input int hi);
    return v >= (lo < 0 ? 0 : lo) && v <= hi;
  endfunction
endpackage

// File: rtl/lane_object.sv
// lane_object: one obstacle lane - X register, step/wrap, player hit and pixel test
//   i_clr clears X, i_adv advances X by i_step (0 disables the lane entirely);
//   o_wrap/o_hit describe the candidate next position, o_pix is combinational.
module lane_object import game_pkg::*; #(
  parameter int COORD_W       = DEF_COORD_W,
  parameter int SCREEN_W      = 640,
  parameter int PLAYER_X_MIN  = 280,
  parameter int PLAYER_X_MAX  = 320,
  parameter int PLAYER_HALF_H = 10,
  parameter int LANE_H        = 15,
  parameter int OBJ_HALF_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_adv,
  input  logic [2:0]         i_step,
  input  logic [COORD_W-1:0] i_top,
  input  logic [COORD_W-1:0] i_player_y,
  input  logic [COORD_W-1:0] i_cx,
  input  logic [COORD_W-1:0] i_cy,
  output logic               o_wrap,
  output logic               o_hit,
  output logic               o_pix
);
  logic [COORD_W-1:0] r_x;
  logic w_en;
  int w_x, w_top, w_py, w_sum, w_nx;
  always_comb begin
    w_en   = i_step != 3'd0;
    w_x    = int'(r_x);
    w_top  = int'(i_top);
    w_py   = int'(i_player_y);
    w_sum  = w_x + int'(i_step);
    o_wrap = w_en && w_sum >= SCREEN_W;
    w_nx   = o_wrap ? w_sum - SCREEN_W : w_sum;
    o_hit  = w_en && w_nx + OBJ_HALF_W >= PLAYER_X_MIN && w_nx - OBJ_HALF_W <= PLAYER_X_MAX &&
             w_py - PLAYER_HALF_H <= w_top + LANE_H - 1 && w_py + PLAYER_HALF_H >= w_top;
    o_pix  = w_en && in_range(int'(i_cx), w_x - OBJ_HALF_W, w_x + OBJ_HALF_W) &&
             in_range(int'(i_cy), w_top, w_top + LANE_H - 1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_x <= '0;
    else if (i_clr) r_x <= '0;
    else if (i_adv) r_x <= COORD_W'(w_nx);
endmodule

// File: rtl/lane_obstacle_engine.sv
// lane_obstacle_engine: multi-lane obstacle game engine with collision, score and FSM
//   clk/reset/start/tick control the game; player_y, lane_top, lane_step configure it;
//   counter_x/counter_y select the pixel; obj_pix/player_pix are registered pixel bits;
//   state, score and hit_lane report game status.
module lane_obstacle_engine import game_pkg::*; #(
  parameter int NUM_LANES     = 4,
  parameter int COORD_W       = DEF_COORD_W,
  parameter int SCREEN_W      = 640,
  parameter int PLAYER_X_MIN  = 280,
  parameter int PLAYER_X_MAX  = 320,
  parameter int PLAYER_HALF_H = 10,
  parameter int LANE_H        = 15,
  parameter int OBJ_HALF_W    = 5,
  parameter int SCORE_W       = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         tick,
  input  logic [COORD_W-1:0]           player_y,
  input  logic [NUM_LANES*COORD_W-1:0] lane_top,
  input  logic [NUM_LANES*3-1:0]       lane_step,
  input  logic [COORD_W-1:0]           counter_x,
  input  logic [COORD_W-1:0]           counter_y,
  output logic                         obj_pix,
  output logic                         player_pix,
  output logic [1:0]                   state,
  output logic [SCORE_W-1:0]           score,
  output logic [NUM_LANES-1:0]         hit_lane
);
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;
  state_t r_state;
  logic [NUM_LANES-1:0] w_wrap, w_hit, w_pix;
  logic w_clr, w_adv, w_ply;
  int w_cnt, w_sum;
  assign state = r_state;
  assign w_clr = tick && start && r_state == IDLE;
  // A tick that drops start leaves PLAY without moving anything.
  assign w_adv = tick && start && r_state == PLAY;
  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_object #(
        .COORD_W(COORD_W), .SCREEN_W(SCREEN_W), .PLAYER_X_MIN(PLAYER_X_MIN),
        .PLAYER_X_MAX(PLAYER_X_MAX), .PLAYER_HALF_H(PLAYER_HALF_H),
        .LANE_H(LANE_H), .OBJ_HALF_W(OBJ_HALF_W)
      ) u_lane (
        .clk(clk), .reset(reset), .i_clr(w_clr), .i_adv(w_adv),
        .i_step(lane_step[g*3 +: 3]), .i_top(lane_top[g*COORD_W +: COORD_W]),
        .i_player_y(player_y), .i_cx(counter_x), .i_cy(counter_y),
        .o_wrap(w_wrap[g]), .o_hit(w_hit[g]), .o_pix(w_pix[g])
      );
    end
  endgenerate
  always_comb begin
    w_cnt = 0;
    for (int i = 0; i < NUM_LANES; i++) w_cnt += int'(w_wrap[i]);
    w_sum = int'(score) + w_cnt;
    w_ply = in_range(int'(counter_x), PLAYER_X_MIN, PLAYER_X_MAX) &&
            in_range(int'(counter_y), int'(player_y) - PLAYER_HALF_H, int'(player_y) + PLAYER_HALF_H);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      score      <= '0;
      hit_lane   <= '0;
      obj_pix    <= 1'b0;
      player_pix <= 1'b0;
    end else begin
      obj_pix    <= |w_pix;
      player_pix <= w_ply;
      if (tick)
        case (r_state)
          IDLE: if (start) begin
            r_state  <= PLAY;
            score    <= '0;
            hit_lane <= '0;
          end
          PLAY: if (!start) r_state <= IDLE;
          else if (|w_hit) begin
            r_state  <= OVER;
            hit_lane <= w_hit;
          end else score <= SCORE_W'(w_sum > SCORE_MAX ? SCORE_MAX : w_sum);
          OVER: if (!start) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_lane_obstacle_engine.sv
// tb_lane_obstacle_engine: directed self-checking bench for lane_obstacle_engine
module tb_lane_obstacle_engine;
  logic clk = 1'b0;
  logic reset, start, tick;
  logic [9:0] player_y, counter_x, counter_y;
  logic [9:0] top [4];
  logic [2:0] stp [4];
  logic [39:0] lane_top;
  logic [11:0] lane_step;
  logic obj_pix, player_pix;
  logic [1:0] state;
  logic [9:0] score;
  logic [3:0] hit_lane;
  int checks = 0, failures = 0;
  typedef struct {int cx; int cy; int obj; int ply;} pv_t;
  pv_t pv [13];
  assign lane_top  = {top[3], top[2], top[1], top[0]};
  assign lane_step = {stp[3], stp[2], stp[1], stp[0]};
  always #5 clk = ~clk;
  lane_obstacle_engine dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .player_y(player_y),
    .lane_top(lane_top), .lane_step(lane_step), .counter_x(counter_x), .counter_y(counter_y),
    .obj_pix(obj_pix), .player_pix(player_pix), .state(state), .score(score), .hit_lane(hit_lane)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(posedge clk);
    #1 tick = 1'b0;
  endtask
  task automatic pix(input string name, input int cx, input int cy, input int obj, input int ply);
    counter_x = 10'(cx);
    counter_y = 10'(cy);
    @(posedge clk);
    #1;
    chk({name, "_obj"}, int'(obj_pix), obj);
    chk({name, "_ply"}, int'(player_pix), ply);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0;
    player_y = 10'd50; counter_x = '0; counter_y = '0;
    top[0] = 10'd200; top[1] = 10'd150; top[2] = 10'd300; top[3] = 10'd250;
    stp[0] = 3'd4; stp[1] = 3'd0; stp[2] = 3'd0; stp[3] = 3'd0;
    pv = '{'{0, 200, 1, 0}, '{5, 200, 1, 0}, '{6, 200, 0, 0}, '{0, 214, 1, 0},
           '{0, 215, 0, 0}, '{0, 199, 0, 0}, '{280, 40, 0, 1}, '{320, 60, 0, 1},
           '{279, 50, 0, 0}, '{321, 50, 0, 0}, '{300, 39, 0, 0}, '{300, 61, 0, 0},
           '{0, 150, 0, 0}};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_hit", int'(hit_lane), 0);
    chk("rst_obj", int'(obj_pix), 0);
    chk("rst_ply", int'(player_pix), 0);
    start = 1'b1;
    ticks(2);
    chk("tick_in_reset", int'(state), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    ticks(1);
    chk("enter_play", int'(state), 1);
    chk("enter_score", int'(score), 0);
    foreach (pv[i]) pix($sformatf("pv%0d", i), pv[i].cx, pv[i].cy, pv[i].obj, pv[i].ply);
    ticks(159);
    chk("pre_wrap_score", int'(score), 0);
    pix("x636", 636, 200, 1, 0);
    ticks(1);
    chk("wrap_score", int'(score), 1);
    chk("wrap_state", int'(state), 1);
    pix("x0", 0, 200, 1, 0);
    stp[1] = 3'd4;
    ticks(159);
    chk("pre_dual_score", int'(score), 1);
    ticks(1);
    chk("dual_score", int'(score), 3);
    pix("pre_rst", 300, 50, 0, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_hit", int'(hit_lane), 0);
    chk("arst_ply", int'(player_pix), 0);
    chk("arst_obj", int'(obj_pix), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    player_y = 10'd207;
    stp[0] = 3'd1; stp[1] = 3'd7;
    ticks(1);
    chk("hit_enter", int'(state), 1);
    ticks(274);
    chk("pre_hit_state", int'(state), 1);
    chk("pre_hit_score", int'(score), 2);
    ticks(1);
    chk("hit_state", int'(state), 2);
    chk("hit_score", int'(score), 2);
    chk("hit_lane", int'(hit_lane), 1);
    pix("over_x", 270, 200, 1, 0);
    ticks(10);
    chk("over_hold", int'(state), 2);
    chk("over_score", int'(score), 2);
    pix("over_frozen", 275, 200, 1, 0);
    start = 1'b0;
    ticks(1);
    chk("over_idle", int'(state), 0);
    start = 1'b1;
    ticks(1);
    chk("replay_state", int'(state), 1);
    chk("replay_score", int'(score), 0);
    chk("replay_hit", int'(hit_lane), 0);
    pix("replay_x0", 0, 200, 1, 0);
    player_y = 10'd400;
    top[0] = 10'd100; top[1] = 10'd150; top[2] = 10'd200; top[3] = 10'd250;
    foreach (stp[i]) stp[i] = 3'd7;
    ticks(23315);
    chk("sat_1020", int'(score), 1020);
    ticks(91);
    chk("sat_1023", int'(score), 1023);
    ticks(92);
    chk("sat_hold", int'(score), 1023);
    chk("sat_state", int'(state), 1);
    start = 1'b0;
    ticks(1);
    chk("idle_state", int'(state), 0);
    chk("idle_keep_score", int'(score), 1023);
    start = 1'b1;
    ticks(1);
    foreach (stp[i]) stp[i] = 3'd0;
    stp[2] = 3'd5;
    top[2] = 10'd300;
    ticks(56);
    chk("l2_run", int'(state), 1);
    pix("l2_on", 280, 300, 1, 0);
    stp[2] = 3'd0;
    player_y = 10'd307;
    pix("l2_off", 280, 300, 0, 1);
    ticks(3);
    chk("l2_nohit", int'(state), 1);
    pix("l2_band", 285, 310, 0, 1);
    stp[2] = 3'd2;
    pix("l2_show", 283, 300, 1, 1);
    ticks(1);
    chk("l2_hit_state", int'(state), 2);
    chk("l2_hit_lane", int'(hit_lane), 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lane_obstacle_engine.md
# lane_obstacle_engine

Parametrised game-object engine for the VGA game datapath. It generalises the fixed two-bullet, hard-coded-lane logic to NUM_LANES independent horizontal obstacle lanes, each with a per-lane speed. It adds player-box collision detection, a saturating score, and an IDLE/PLAY/OVER state machine. It sits between the clock divider (which supplies a one-cycle `tick`), the player-position logic, and the `hvsync_generator` pixel counters, and it produces the registered obstacle/player pixel bits consumed by the RGB output stage.

## Interface
Parameters:
- NUM_LANES, 4, number of obstacle lanes (1..8)
- COORD_W, 10, width of all X/Y coordinates
- SCREEN_W, 640, horizontal wrap limit; obstacle X range is 0..SCREEN_W-1
- PLAYER_X_MIN, 280, left edge of player box (inclusive)
- PLAYER_X_MAX, 320, right edge of player box (inclusive)
- PLAYER_HALF_H, 10, player box spans player_y±PLAYER_HALF_H
- LANE_H, 15, lane band height; lane i spans lane_top[i]..lane_top[i]+LANE_H-1
- OBJ_HALF_W, 5, obstacle spans x±OBJ_HALF_W
- SCORE_W, 10, score width

Ports:
- clk  in  1  system pixel-domain clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  level; game enable switch
- tick  in  1  one-clk-wide game-step strobe
- player_y  in  COORD_W  player box centre Y
- lane_top  in  NUM_LANES*COORD_W  packed lane band top Y; lane 0 in the LSBs
- lane_step  in  NUM_LANES*3  packed per-lane pixels-per-tick; 0 means the lane is disabled and invisible
- counter_x, counter_y  in  COORD_W each  current pixel from the sync generator
- obj_pix  out  1  registered: the current pixel lies in an enabled obstacle
- player_pix  out  1  registered: the current pixel lies in the player box
- state  out  2  IDLE=0, PLAY=1, OVER=2
- score  out  SCORE_W  number of obstacles completed, saturating
- hit_lane  out  NUM_LANES  one-hot-or-more; the lanes that caused game over

## Operation
- FSM:
  - IDLE→PLAY on the first `tick` with start=1.
  - PLAY→OVER on a tick where any hit is detected.
  - PLAY→IDLE on a tick with start=0; positions and score are retained.
  - OVER→IDLE on a tick with start=0.
  - Transitions are evaluated only on tick cycles.
- Entering PLAY from IDLE clears all lane X to 0, clears score, and clears hit_lane.
- In PLAY, each tick, for every lane with step≠0:
  - nx = x+step.
  - If nx ≥ SCREEN_W: nx = nx−SCREEN_W and the lane sets wrap[i].
  - Arithmetic is done at COORD_W+1 bits.
- Hit for lane i (evaluated on nx, same tick), all of the following must hold:
  - step≠0.
  - nx+OBJ_HALF_W ≥ PLAYER_X_MIN.
  - nx−OBJ_HALF_W ≤ PLAYER_X_MAX, with signed compare, no underflow wrap.
  - Player band [player_y−PLAYER_HALF_H, player_y+PLAYER_HALF_H] overlaps the lane band.
- No hit on a tick: X←nx, and score ← score + popcount(wrap), saturating at 2^SCORE_W−1.
- Any hit on a tick: X←nx, hit_lane←hit vector, state←OVER, and the score is NOT incremented that tick even if lanes wrap.
- In IDLE and OVER, X and score are frozen; obstacles remain drawn.
- Pixel logic:
  - obj_pix = OR over enabled lanes of (counter_x within x±OBJ_HALF_W AND counter_y within the lane band).
  - player_pix = counter_x in [PLAYER_X_MIN, PLAYER_X_MAX] AND counter_y within player_y±PLAYER_HALF_H.
  - Negative lower bounds clamp to 0.
- A lane_step change takes effect on the next tick. A lane_step change to 0 hides the lane immediately on the pixel path.

## Timing
- Reset values: state=IDLE, score=0, hit_lane=0, all X=0, obj_pix=0, player_pix=0.
- Reset asserted mid-game returns everything to these values asynchronously.
- State, X, score, and hit_lane update on the clk edge where tick=1. Outputs are visible one cycle after that edge.
- Pixel latency is 1 clk: obj_pix/player_pix at cycle n+1 reflect counter_x/counter_y at cycle n, using X values as registered at cycle n.
- tick held high for multiple cycles is treated as multiple ticks. Back-to-back ticks must be supported.
- A tick during reset is ignored.

## Structure
- Package `game_pkg`: state enum (IDLE/PLAY/OVER), COORD_W default, the `in_range(v, lo, hi)` helper with clamped lower bound.
- Sub-module `lane_object`: one lane's X register, step/wrap arithmetic, hit compare, and pixel compare. It is instantiated NUM_LANES times via generate.
- Top level: FSM, popcount plus saturating score, and the pixel OR-reduction register.

## Test plan
- Reset then start=1 with one tick → state=PLAY, all X=0, score=0; assert reset mid-PLAY → all outputs return to their reset values the same cycle.
- Lane 0 step=4, lane_top=200, player_y=50, 160 ticks → lane 0 X wraps exactly once (636→0), score=1, state=PLAY.
- Lanes 0 and 1 both step=4 with no collision, 160 ticks → both wrap on the same tick, score increments by 2.
- player_y=207, lane_top[0]=200, step=1; tick until X=275 (275+5=280) → state=OVER on that tick, hit_lane=0001, score unchanged even though lane 1 wraps on the same tick.
- score preloaded to 1023 (SCORE_W=10) via run-up, one further wrap → score stays 1023.
- Lane 2 step=0 → never hits, obj_pix=0 across its band; set step=2 → obj_pix=1 at (x, lane_top[2]) one clk after the counters present that pixel.
